// File: rtl/s298_misr_if.sv
// Handshake and data bundle between the s298 test harness and the response
// compactor. The harness drives the session request, golden value, acknowledge
// and the six s298 outputs. The compactor drives the signature and status back.
interface s298_misr_if #(
  parameter int unsigned SIG_W = 16,
  parameter int unsigned CNT_W = 16
);
  logic             START;
  logic [CNT_W-1:0] NPAT;
  logic [SIG_W-1:0] GOLD;
  logic             ACK;
  logic             G66, G67, G117, G118, G132, G133;
  logic [SIG_W-1:0] SIG;
  logic             BUSY;
  logic             DONE;
  logic             PASS;

  modport master (
    output START, NPAT, GOLD, ACK, G66, G67, G117, G118, G132, G133,
    input  SIG, BUSY, DONE, PASS
  );

  modport slave (
    input  START, NPAT, GOLD, ACK, G66, G67, G117, G118, G132, G133,
    output SIG, BUSY, DONE, PASS
  );
endinterface

// File: rtl/s298_misr.sv
// Response compactor for the s298 core. It folds the six s298 outputs into a
// multiple-input signature register over NPAT cycles. It then holds the result
// and compares it against a golden signature until the harness acknowledges.
module s298_misr #(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h100B,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
  parameter int unsigned      CNT_W = 16
) (
  input logic          CK,
  input logic          RN,
  s298_misr_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] gld_q, gld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SIG_W-1:0] data_w;
  logic [SIG_W-1:0] step_w;

  // Pack the s298 outputs into the low bits of the data word; upper bits are zero.
  always_comb begin
    data_w      = '0;
    data_w[5:0] = {bus.G133, bus.G132, bus.G118, bus.G117, bus.G67, bus.G66};
  end

  // One MISR step: shift left, fold the feedback polynomial on MSB carry-out, mix in data.
  assign step_w = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ data_w;

  // Session control: load on START in IDLE, compact in RUN, hold result in DONE until ACK.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    sig_d   = sig_q;
    gld_d   = gld_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          sig_d = SEED;
          cnt_d = bus.NPAT;
          gld_d = bus.GOLD;
          if (bus.NPAT == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        sig_d = step_w;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.ACK) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, signature, counter, golden latch and registered status flags.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      gld_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so all flops see pre-edge values of each other.
      state_q <= state_d;
      sig_q   <= sig_d;
      gld_q   <= gld_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.SIG  = sig_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  // PASS is qualified by DONE so it reads 0 whenever the result is not being reported.
  assign bus.PASS = done_q & (sig_q == gld_q);

endmodule

// File: tb/tb_s298_misr.sv
// Bench for the s298 response compactor. Expected signatures come from a small
// reference MISR and a behavioral s298 stand-in. They are queued when a session
// starts and compared when the DUT raises DONE.
module tb_s298_misr;

  localparam logic [15:0] SEED_V = 16'hFFFF;
  localparam logic [15:0] POLY_V = 16'h100B;

  typedef struct packed {
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  logic ck;
  logic rn;
  s298_misr_if #(.SIG_W(16), .CNT_W(16)) bus ();

  s298_misr #(
    .SIG_W(16), .POLY(POLY_V), .SEED(SEED_V), .CNT_W(16)
  ) dut (
    .CK (ck),
    .RN (rn),
    .bus(bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_chk = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [5:0] pat [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [5:0] d);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ POLY_V;
    return n ^ {10'b0, d};
  endfunction

  task automatic set_g(input logic [5:0] d);
    bus.G66  = d[0];
    bus.G67  = d[1];
    bus.G117 = d[2];
    bus.G118 = d[3];
    bus.G132 = d[4];
    bus.G133 = d[5];
  endtask

  task automatic expect_done(input string tag);
    int waited = 0;
    check({tag, "_done_on_time"}, 32'(bus.DONE), 32'd1);
    while (!bus.DONE && waited < 8) begin
      @(negedge ck);
      waited++;
    end
    if (!bus.DONE) check({tag, "_done_timeout"}, 32'(bus.DONE), 32'd1);
  endtask

  // Runs one session over pat[0..n-1]; optionally pokes START mid-RUN.
  task automatic run_session(input string tag, input int n, input logic [15:0] gold, input bit poke);
    exp_t e;
    logic [15:0] s = SEED_V;
    for (int j = 0; j < n; j++) s = misr_ref(s, pat[j]);
    e.sig  = s;
    e.pass = (s == gold);
    sb.push_back(e);
    @(negedge ck);
    bus.START = 1'b1;
    bus.NPAT  = 16'(n);
    bus.GOLD  = gold;
    @(negedge ck);
    bus.START = 1'b0;
    bus.NPAT  = 16'h0003;
    bus.GOLD  = ~gold;
    check({tag, "_busy_after_start"}, 32'(bus.BUSY), 32'(n > 0));
    for (int j = 0; j < n; j++) begin
      set_g(pat[j]);
      bus.START = (poke && j == n / 2);
      bus.NPAT  = '0;
      @(negedge ck);
    end
    bus.START = 1'b0;
    set_g(6'h2A);
    check({tag, "_busy_low"}, 32'(bus.BUSY), 32'd0);
    expect_done(tag);
    e = sb.pop_front();
    check({tag, "_sig"}, 32'(bus.SIG), 32'(e.sig));
    check({tag, "_pass"}, 32'(bus.PASS), 32'(e.pass));
  endtask

  task automatic ack_session(input string tag);
    @(negedge ck);
    bus.ACK = 1'b1;
    @(negedge ck);
    bus.ACK = 1'b0;
    check({tag, "_done_cleared"}, 32'(bus.DONE), 32'd0);
    check({tag, "_pass_forced_low"}, 32'(bus.PASS), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] held_sig;
    logic [13:0] st;
    logic [2:0]  gi;
    logic [15:0] live_gold;

    rn = 1'b0;
    bus.START = 1'b0;
    bus.NPAT  = '0;
    bus.GOLD  = '0;
    bus.ACK   = 1'b0;
    set_g('0);
    repeat (3) @(negedge ck);
    check("reset_sig", 32'(bus.SIG), 32'hFFFF);
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    check("reset_done", 32'(bus.DONE), 32'd0);
    check("reset_pass", 32'(bus.PASS), 32'd0);
    rn = 1'b1;

    // Single step, zero data: EFF5 matches gold.
    pat[0] = 6'h00;
    run_session("one_zero", 1, 16'hEFF5, 1'b0);
    check("one_zero_sig_const", 32'(bus.SIG), 32'hEFF5);
    ack_session("one_zero");
    check("idle_sig_held", 32'(bus.SIG), 32'hEFF5);

    // Single step, all ones: EFCA, gold mismatch.
    pat[0] = 6'h3F;
    run_session("one_ones", 1, 16'hEFF5, 1'b0);
    check("one_ones_sig_const", 32'(bus.SIG), 32'hEFCA);
    ack_session("one_ones");

    // Two zero steps.
    pat[0] = 6'h00;
    pat[1] = 6'h00;
    run_session("two_zero", 2, 16'hCFE1, 1'b0);
    check("two_zero_sig_const", 32'(bus.SIG), 32'hCFE1);
    ack_session("two_zero");

    // NPAT = 0: DONE right after the start edge with SEED.
    run_session("npat0", 0, 16'hFFFF, 1'b0);
    check("npat0_pass_const", 32'(bus.PASS), 32'd1);
    ack_session("npat0");

    // Handshake corners: START poked in RUN, then held DONE with START pulses.
    for (int j = 0; j < 5; j++) pat[j] = 6'($urandom_range(0, 63));
    run_session("poke", 5, 16'h1234, 1'b1);
    held_sig = bus.SIG;
    for (int c = 0; c < 20; c++) begin
      bus.START = c[0];
      bus.NPAT  = 16'd7;
      @(negedge ck);
      check("hold_done", 32'(bus.DONE), 32'd1);
      check("hold_sig", 32'(bus.SIG), 32'(held_sig));
      check("hold_pass", 32'(bus.PASS), 32'(held_sig == 16'h1234));
    end
    bus.START = 1'b1;
    bus.ACK   = 1'b1;
    @(negedge ck);
    bus.START = 1'b0;
    bus.ACK   = 1'b0;
    check("start_ack_done", 32'(bus.DONE), 32'd0);
    check("start_ack_busy", 32'(bus.BUSY), 32'd0);
    @(negedge ck);
    check("no_session_busy", 32'(bus.BUSY), 32'd0);
    check("no_session_done", 32'(bus.DONE), 32'd0);
    check("no_session_sig", 32'(bus.SIG), 32'(held_sig));

    // Reset in the middle of a 100-cycle session.
    @(negedge ck);
    bus.START = 1'b1;
    bus.NPAT  = 16'd100;
    bus.GOLD  = 16'h0000;
    @(negedge ck);
    bus.START = 1'b0;
    for (int c = 0; c < 39; c++) begin
      set_g(6'($urandom_range(0, 63)));
      @(negedge ck);
    end
    check("mid_run_busy", 32'(bus.BUSY), 32'd1);
    #2 rn = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.BUSY), 32'd0);
    check("rst_mid_done", 32'(bus.DONE), 32'd0);
    check("rst_mid_sig", 32'(bus.SIG), 32'hFFFF);
    @(negedge ck);
    rn = 1'b1;
    repeat (3) @(negedge ck);
    check("after_rst_idle_busy", 32'(bus.BUSY), 32'd0);
    check("after_rst_idle_done", 32'(bus.DONE), 32'd0);
    for (int j = 0; j < 3; j++) pat[j] = 6'($urandom_range(0, 63));
    run_session("after_rst", 3, 16'h0000, 1'b0);
    ack_session("after_rst");

    // Live run: behavioral s298 stand-in from reset state, fixed G0-G2 sequence.
    st = '0;
    for (int j = 0; j < 1000; j++) begin
      gi = 3'((j * 5 + j / 7) % 8);
      pat[j] = {st[13] ^ gi[2], st[11] & st[3], st[9] | gi[1],
                st[6] ^ st[2], st[4] & ~gi[0], st[0] ^ st[7]};
      st = {st[12:0], st[13] ^ st[10] ^ gi[0]} ^ {11'b0, gi};
    end
    live_gold = SEED_V;
    for (int j = 0; j < 1000; j++) live_gold = misr_ref(live_gold, pat[j]);
    run_session("live", 1000, live_gold, 1'b0);
    check("live_pass_true", 32'(bus.PASS), 32'd1);
    ack_session("live");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
